// File: rtl/sub_32_serial.sv
// Multi-cycle 32-bit subtractor: diff = in1 - in2 - bin, CHUNK bits per cycle, valid/ready handshake.
// Optional signed-overflow output ovf enabled by defining SUB_OVERFLOW_EN.
module sub_32_serial #(
  parameter int unsigned CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
`ifdef SUB_OVERFLOW_EN
  output logic        ovf,
`endif
  output logic        bout
);

  localparam int unsigned N     = 32 / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  if (!(CHUNK == 1 || CHUNK == 2 || CHUNK == 4 || CHUNK == 8 ||
        CHUNK == 16 || CHUNK == 32)) begin : g_bad_chunk
    $error("sub_32_serial: CHUNK must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [31:0]        a_q,         a_d;
  logic [31:0]        b_q,         b_d;
  logic               borrow_q,    borrow_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic [31:0]        diff_q,      diff_d;
  logic               bout_q,      bout_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;
`ifdef SUB_OVERFLOW_EN
  logic               ovf_q,       ovf_d;
`endif

  logic [CHUNK-1:0]   a_s, b_s;
  logic [CHUNK:0]     slice_full;
  int unsigned        base;

  // Current slice: the extra top bit of the widened difference is the borrow-out.
  always_comb begin
    base       = 32'(idx_q) * CHUNK;
    a_s        = a_q[base +: CHUNK];
    b_s        = b_q[base +: CHUNK];
    slice_full = {1'b0, a_s} - {1'b0, b_s} - {{CHUNK{1'b0}}, borrow_q};
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    borrow_d    = borrow_q;
    idx_d       = idx_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = in1;
          b_d        = in2;
          borrow_d   = bin;
          idx_d      = '0;
          diff_d     = '0;
          bout_d     = 1'b0;
`ifdef SUB_OVERFLOW_EN
          ovf_d      = 1'b0;
`endif
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        diff_d[base +: CHUNK] = slice_full[CHUNK-1:0];
        borrow_d              = slice_full[CHUNK];
        if (idx_q == IDX_W'(N - 1)) begin
          bout_d      = slice_full[CHUNK];
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef SUB_OVERFLOW_EN
          // Sign-based form, equivalent to borrow-into-bit-31 XOR borrow-out.
          ovf_d = (a_q[31] ^ b_q[31]) & (a_q[31] ^ slice_full[CHUNK-1]);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      borrow_q    <= 1'b0;
      idx_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      borrow_q    <= borrow_d;
      idx_q       <= idx_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SUB_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_sub_32_serial.sv
// Directed self-checking bench for sub_32_serial (CHUNK=8); checks ovf when SUB_OVERFLOW_EN is defined.
module tb_sub_32_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1, in2;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
`ifdef SUB_OVERFLOW_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  sub_32_serial #(.CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SUB_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .bout      (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge, then wait for out_valid and compare.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic [31:0] exp_d, input logic exp_b,
                        input logic exp_o);
    int lat;
    in_valid = 1'b1;
    in1      = a;
    in2      = b;
    bin      = c;
    tick();
    in_valid = 1'b0;
    in1      = ~a;
    in2      = ~b;
    bin      = ~c;
    check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (out_valid === 1'b1) break;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_diff"}, diff, exp_d);
    check({tag, "_bout"}, 32'(bout), 32'(exp_b));
`ifdef SUB_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
`else
    if (exp_o) begin end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_retired"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    bin       = 1'b0;
    out_ready = 1'b0;
    #2;
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_diff",      diff,           32'd0);
    check("reset_bout",      32'(bout),      32'd0);
    #10 rst = 1'b0;

    run_op("basic",    32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    run_op("underflow",32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("xborrow",  32'h0000_0100, 32'h0000_00FF, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    run_op("allones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("mixed",    32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0123_4567, 1'b0, 1'b0);
    run_op("sovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op("sovf_neg", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);

    // Back-pressure in DONE with new operands offered the whole time.
    in_valid = 1'b1; in1 = 32'h0000_00A0; in2 = 32'h0000_000A; bin = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (out_valid === 1'b1) break;
    end
    check("hold_latency", 32'(lat), 32'd4);
    in_valid = 1'b1; in1 = 32'hDEAD_BEEF; in2 = 32'h0000_0001; bin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_diff",      diff,           32'h0000_0096);
      check("hold_bout",      32'(bout),      32'd0);
      check("hold_in_ready",  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_retired",      32'(out_valid), 32'd0);
    check("hold_no_take_idle", 32'(in_ready),  32'd1);
    tick();
    in_valid = 1'b0;
    check("next_accepted", 32'(in_ready), 32'd0);
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (out_valid === 1'b1) break;
    end
    check("next_latency", 32'(lat), 32'd4);
    check("next_diff", diff, 32'hDEAD_BEEE);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset after two slices aborts the operation.
    in_valid = 1'b1; in1 = 32'h0000_FFFF; in2 = 32'h0000_0001; bin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("abort_partial_diff", diff, 32'h0000_FFFE);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_diff",      diff,           32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_no_stale", 32'(out_valid), 32'd0);
    end
    run_op("post_abort", 32'h0000_0010, 32'h0000_0020, 1'b1, 32'hFFFF_FFEF, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
